// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: refills one cache block from pipelined main memory.
// When a miss is accepted, the block base address is latched and WORDS
// back-to-back word reads are issued. Every returned word is steered into the
// data set with a one-hot word enable. The tag is written together with the
// last word, and at that point the pipeline stall is released.
module cache_fill_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int WORDS    = 8,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_read_en,
    output logic              write_data_array,
    output logic [WORDS-1:0]  word_enable,
    output logic              write_tag_array,
    output logic              fill_done
);

    // The word index occupies the offset field above the byte-select bit.
    localparam int IDX_W = OFFSET_W - 1;
    // Counters need one extra bit so they can hold WORDS itself.
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = ADDR_W - OFFSET_W;

    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(WORDS - 1);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_recv_cnt;
    logic [TAG_W-1:0]   r_base_hi;

    logic               w_accept;
    logic               w_issue;
    logic               w_recv;
    logic               w_last;
    logic [IDX_W-1:0]   w_issue_idx;
    logic               w_unused_ok;

    // The offset bits of the miss address do not matter because the whole block is refilled.
    assign w_unused_ok = &{1'b0, miss_address[OFFSET_W-1:0]};

    assign w_accept = (r_state == S_IDLE) && miss_detected;
    assign w_issue  = (r_state == S_FILL) && (r_issue_cnt < WORDS_C);
    assign w_recv   = (r_state == S_FILL) && memory_data_valid && (r_recv_cnt < WORDS_C);
    assign w_last   = w_recv && (r_recv_cnt == LAST_C);

    // Once issuing has finished, the address stays parked on the last word of the block.
    assign w_issue_idx = (r_issue_cnt < WORDS_C) ? r_issue_cnt[IDX_W-1:0] : LAST_IX;

    // State, counter and base-address registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base_hi   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_base_hi   <= miss_address[ADDR_W-1:OFFSET_W];
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_recv) begin
                    r_recv_cnt <= r_recv_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic: accept a miss while idle, and return to idle on the final word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (miss_detected) w_state_nxt = S_FILL;
            S_FILL:  if (w_last)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: requests, data-array steering and completion strobes.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_enable      = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        if (r_state == S_FILL) begin
            fsm_busy       = 1'b1;
            mem_read_en    = w_issue;
            memory_address = {r_base_hi, w_issue_idx, 1'b0};
            if (w_recv) begin
                write_data_array = 1'b1;
                word_enable      = WORDS'(1) << r_recv_cnt[IDX_W-1:0];
            end
            write_tag_array = w_last;
            fill_done       = w_last;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed scoreboard bench for cache_fill_ctrl.
// Each time the bench starts a fill, it queues the expected request addresses
// and the expected word-enable writes. These entries are popped as the DUT
// issues requests and performs writes.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic [15:0] memory_address;
    logic        mem_read_en;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic        write_tag_array;
    logic        fill_done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] req_q[$];
    logic [8:0]  wr_q[$];

    cache_fill_ctrl #(.ADDR_W(16), .WORDS(8), .OFFSET_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .memory_address   (memory_address),
        .mem_read_en      (mem_read_en),
        .write_data_array (write_data_array),
        .word_enable      (word_enable),
        .write_tag_array  (write_tag_array),
        .fill_done        (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negative edge: compares the outputs with the expected values and the scoreboard.
    task automatic check_outputs(input logic exp_busy, input logic exp_rd, input logic exp_wr);
        logic [15:0] ea;
        logic [8:0]  ew;
        chk("busy", 32'(fsm_busy), 32'(exp_busy));
        chk("rd_en", 32'(mem_read_en), 32'(exp_rd));
        if (mem_read_en === 1'b1) begin
            chk("req_avail", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) begin
                ea = req_q.pop_front();
                chk("req_addr", 32'(memory_address), 32'(ea));
            end
        end
        chk("wr_en", 32'(write_data_array), 32'(exp_wr));
        if (write_data_array === 1'b1) begin
            chk("wr_avail", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                ew = wr_q.pop_front();
                chk("word_en", 32'(word_enable), 32'(ew[7:0]));
                chk("tag_wr", 32'(write_tag_array), 32'(ew[8]));
                chk("fill_done", 32'(fill_done), 32'(ew[8]));
            end
        end else begin
            chk("word_en_idle", 32'(word_enable), 32'd0);
            chk("tag_wr_idle", 32'(write_tag_array), 32'd0);
            chk("done_idle", 32'(fill_done), 32'd0);
        end
    endtask

    // Runs one clock: drive the inputs, check at the negative edge, then advance past the next positive edge.
    task automatic cycle(input logic miss, input logic [15:0] addr, input logic vld,
                         input logic exp_busy, input logic exp_rd, input logic exp_wr);
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = vld;
        @(negedge clk);
        check_outputs(exp_busy, exp_rd, exp_wr);
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic [15:0] exp_base, input int n_wr);
        for (int i = 0; i < 8; i++) begin
            req_q.push_back(exp_base + 16'(2 * i));
        end
        for (int i = 0; i < n_wr; i++) begin
            wr_q.push_back({(i == 7), 8'(1 << i)});
        end
    endtask

    // One full fill. The miss is held through fill_done. Memory returns its
    // first word four cycles after the first request, with optional random
    // gaps between returns. The miss address can be changed mid-fill.
    task automatic fill(input logic [15:0] maddr, input logic [15:0] exp_base,
                        input bit gapped, input bit chg_addr);
        int          nv;
        int          gap;
        logic        vld;
        logic [15:0] a;
        nv  = 0;
        gap = 0;
        push_fill(exp_base, 8);
        cycle(1'b1, maddr, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; nv < 8 && k < 200; k++) begin
            if (k < 5) begin
                vld = 1'b0;
            end else if (!gapped) begin
                vld = 1'b1;
            end else if (gap > 0) begin
                vld = 1'b0;
                gap--;
            end else begin
                vld = 1'b1;
                gap = int'($urandom_range(3, 0));
            end
            a = (chg_addr && k >= 3) ? 16'hBEEF : maddr;
            cycle(1'b1, a, vld, 1'b1, (k <= 8), vld);
            if (vld) nv++;
        end
        chk("valids_sent", 32'(nv), 32'd8);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(fsm_busy), 32'd0);
        chk("rst_rd", 32'(mem_read_en), 32'd0);
        chk("rst_addr", 32'(memory_address), 32'd0);
        chk("rst_wr", 32'(write_data_array), 32'd0);
        chk("rst_we", 32'(word_enable), 32'd0);
        chk("rst_tag", 32'(write_tag_array), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);

        // Stray valid pulses while idle.
        cycle(1'b0, 16'h1236, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h1236, 1'b1, 1'b0, 1'b0, 1'b0);

        // Basic fill, then a stray valid right after fill_done.
        fill(16'h1236, 16'h1230, 1'b0, 1'b0);
        cycle(1'b0, 16'h1236, 1'b1, 1'b0, 1'b0, 1'b0);

        // The miss address changes mid-fill.
        fill(16'h1236, 16'h1230, 1'b0, 1'b1);
        cycle(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Returns arrive with random gaps.
        fill(16'h2A5C, 16'h2A50, 1'b1, 1'b0);
        cycle(1'b0, 16'h2A5C, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset asserted after three words have been written.
        push_fill(16'h5670, 3);
        cycle(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b1, 16'h5678, (k >= 5), 1'b1, 1'b1, (k >= 5));
        end
        rst = 1'b1;
        cycle(1'b1, 16'h5678, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        miss_detected = 1'b0;
        chk("midrst_busy", 32'(fsm_busy), 32'd0);
        chk("midrst_rd", 32'(mem_read_en), 32'd0);
        chk("midrst_addr", 32'(memory_address), 32'd0);
        chk("midrst_wr", 32'(write_data_array), 32'd0);
        chk("midrst_we", 32'(word_enable), 32'd0);
        chk("midrst_tag", 32'(write_tag_array), 32'd0);
        chk("midrst_done", 32'(fill_done), 32'd0);
        chk("midrst_req_q", 32'(req_q.size()), 32'd0);
        chk("midrst_wr_q", 32'(wr_q.size()), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(16'h00F0, 16'h00F0, 1'b0, 1'b0);
        cycle(1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back misses: the miss stays high through fill_done.
        fill(16'h1236, 16'h1230, 1'b0, 1'b0);
        fill(16'h4000, 16'h4000, 1'b0, 1'b0);
        cycle(1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling controller that refills one cache block (8 x 16-bit words) from main memory into the data/tag arrays.
- Latches the block base address on a miss and issues 8 pipelined word reads to memory.
- Steers each returned word into the data set through a one-hot word_enable, writes the tag with the last word, then releases the pipeline stall.
- Sits between the cache lookup logic, the pipelined multi-cycle memory, and the data/tag arrays.

Parameters:
- ADDR_W, 16, byte-address width.
- WORDS, 8, words per block; must be a power of two; word_enable width.
- OFFSET_W, 4, block-offset bits (log2(WORDS*2)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- miss_detected  in  1  level: lookup missed; requester holds it until fill_done.
- miss_address  in  ADDR_W  address that missed; sampled only on accept.
- memory_data_valid  in  1  memory returns one word this cycle (in issue order).
- fsm_busy  out  1  fill in progress; used as the pipeline stall.
- memory_address  out  ADDR_W  word address of the current read request.
- mem_read_en  out  1  read request strobe.
- write_data_array  out  1  wen to the data set.
- word_enable  out  WORDS  one-hot word select to the data set.
- write_tag_array  out  1  tag/valid write strobe.
- fill_done  out  1  one-cycle pulse on the final word write.

Behaviour:
- Clock, reset and register rules
  - One clock domain (clk); rst is synchronous and active-high.
  - All state updates on posedge clk.
  - rst: state=IDLE, issue_cnt=0, recv_cnt=0, base=0. Every output is 0 in the cycle after rst is sampled, including when rst is asserted mid-fill; any partial fill is abandoned.
- States: IDLE, FILL. Outputs are combinational from state, counters and memory_data_valid.
- IDLE
  - fsm_busy=0, all strobes 0, word_enable=0.
  - miss_detected=1 at an edge: base <= {miss_address[ADDR_W-1:OFFSET_W], 0}, issue_cnt <= 0, recv_cnt <= 0, state <= FILL.
  - No request is issued in the accept cycle.
- FILL: fsm_busy=1.
- Issue side (FILL)
  - mem_read_en = (issue_cnt < WORDS).
  - memory_address = base + 2*issue_cnt, with the offset field taken from issue_cnt only (no carry into tag bits).
  - issue_cnt increments while mem_read_en=1, saturates at WORDS.
  - Exactly 8 requests go out on 8 consecutive cycles. When not issuing, memory_address holds base + 2*(WORDS-1).
- Receive side (FILL)
  - When memory_data_valid=1 and recv_cnt < WORDS: write_data_array=1, word_enable=(1 << recv_cnt), recv_cnt++.
  - Otherwise write_data_array=0 and word_enable=0.
  - The controller counts valids, not cycles, so any memory latency is tolerated.
  - Valids may overlap issue cycles; both counters advance in the same cycle.
- Completion
  - The cycle recv_cnt==WORDS-1 with memory_data_valid=1 also asserts write_tag_array=1 and fill_done=1, and sets state <= IDLE.
  - fsm_busy drops the following cycle.
- Boundary rules
  - memory_data_valid in IDLE is ignored: no writes.
  - miss_detected deasserting mid-fill has no effect; the fill is committed.
  - miss_address changing mid-fill is ignored; base is latched.
  - miss_detected still high in the IDLE cycle after fill_done starts a new fill. The requester must drop it once the tag write makes the lookup hit.
  - A miss is never accepted in the same cycle as fill_done.

Test Plan:
- Basic fill: rst 2 cycles; miss_address=0x1236 held; memory returns valid 4 cycles after each request. Expect requests 0x1230,0x1232,…,0x123E on 8 consecutive cycles starting the cycle after accept. word_enable walks 0x01→0x80 on valid cycles. write_tag_array and fill_done are high only with word_enable=0x80. fsm_busy is 1 for exactly 1+3+8 cycles, then 0.
- Address change: miss_address changed to 0xBEEF mid-fill. Expect addresses to stay in 0x1230–0x123E.
- Gapped returns: valids with random 0–3 cycle gaps. Expect exactly 8 writes in order 0x01..0x80 and fill_done on the 8th; busy holds through the gaps.
- Stray valids: memory_data_valid pulses in IDLE and after fill_done. Expect no write_data_array and word_enable=0.
- Reset mid-fill: rst asserted after 3 words written. Next cycle all outputs 0 and busy=0. A new miss at 0x00F0 then restarts from address 0x00F0 with word_enable=0x01.
- Back-to-back misses: miss_detected held through fill_done with miss_address=0x4000 for the second miss. Expect a second fill to start 1 cycle after IDLE re-entry at base 0x4000.
